// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite bus bundle between the pipeline master and the memory responder.
// Signals:
//   htrans  - transfer type (IDLE/BUSY/NONSEQ/SEQ), master -> responder
//   haddr   - byte address, master -> responder
//   hwrite  - 1 = write, master -> responder
//   hwdata  - write data (data phase), master -> responder
//   hrdata  - read data, responder -> master
//   hready  - transfer done / bus ready, responder -> master
//   hresp   - 0 = OKAY, 1 = ERROR, responder -> master
interface ahb_mem_responder_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output htrans, haddr, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  htrans, haddr, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory-side responder backed by an internal word array.
// Inserts WAIT_STATES hready-low cycles per transfer and answers out-of-window
// addresses with a two-cycle ERROR response.
// Ports:
//   clk       - system clock
//   n_rst     - asynchronous active-low reset
//   bus       - AHB-Lite slave side (htrans, haddr, hwrite, hwdata in;
//               hrdata, hready, hresp out)
//   rd_count  - completed OKAY reads  (only with MEM_ACCESS_COUNT_EN)
//   wr_count  - completed OKAY writes (only with MEM_ACCESS_COUNT_EN)
// Optional feature macro: MEM_ACCESS_COUNT_EN adds the access counters.
module ahb_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  ahb_mem_responder_if.slave  bus
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
`endif
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W     = 4;
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES - 1);
  localparam bit          HAS_WAIT  = (WAIT_STATES != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [IDX_W-1:0]    idx_q;
  logic                write_q;
  logic                hready_q;
  logic                hresp_q;
  logic [DATA_W-1:0]   hrdata_q;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  // Address-phase decode straight off the bus.
  logic [31:0]         offset;
  logic                addr_in_range;
  logic [IDX_W-1:0]    addr_idx;
  logic                accept;
  logic                fwd_hit;
  logic                unused_bits;

  assign offset        = bus.haddr - ADDR_BASE;
  assign addr_in_range = (offset < WIN_BYTES);
  assign addr_idx      = offset[IDX_W+1:2];
  assign accept        = hready_q && bus.htrans[1];
  // A write finishing on the same edge a read is accepted: hand the write data over.
  assign fwd_hit       = (state == S_DATA) && write_q && (idx_q == addr_idx);
  assign unused_bits   = ^{offset[1:0], offset[31:IDX_W+2], bus.htrans[0]};

  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;
  assign bus.hrdata = hrdata_q;

  // Transfer FSM with registered bus responses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DATA, S_ERR2: begin
          if (accept) begin
            idx_q   <= addr_idx;
            write_q <= bus.hwrite;
            if (!addr_in_range) begin
              state    <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (HAS_WAIT) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
            end else begin
              state    <= S_DATA;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
              if (!bus.hwrite) begin
                hrdata_q <= fwd_hit ? bus.hwdata : mem[addr_idx];
              end
            end
          end else begin
            state    <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= S_DATA;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            if (!write_q) begin
              hrdata_q <= mem[idx_q];
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_ERR1: begin
          state    <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write data lands at the end of the write data phase; contents are not reset.
  always_ff @(posedge clk) begin
    if (state == S_DATA && write_q) begin
      mem[idx_q] <= bus.hwdata;
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Completed OKAY accesses; error transfers never reach S_DATA.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == S_DATA) begin
      if (write_q) begin
        wr_count <= wr_count + 32'd1;
      end else begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench for ahb_mem_responder: three instances with WAIT_STATES of
// 1, 0 and 3 share one stimulus bus; sel routes the bus to one of them and
// parks the others at IDLE.
module tb_ahb_mem_responder;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  sel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;

  logic        cur_hready;
  logic        cur_hresp;
  logic [31:0] cur_hrdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahb_mem_responder_if b0 ();
  ahb_mem_responder_if b1 ();
  ahb_mem_responder_if b2 ();

  assign b0.htrans = (sel == 2'd0) ? htrans : 2'b00;
  assign b0.haddr  = (sel == 2'd0) ? haddr  : 32'h0;
  assign b0.hwrite = (sel == 2'd0) ? hwrite : 1'b0;
  assign b0.hwdata = (sel == 2'd0) ? hwdata : 32'h0;
  assign b1.htrans = (sel == 2'd1) ? htrans : 2'b00;
  assign b1.haddr  = (sel == 2'd1) ? haddr  : 32'h0;
  assign b1.hwrite = (sel == 2'd1) ? hwrite : 1'b0;
  assign b1.hwdata = (sel == 2'd1) ? hwdata : 32'h0;
  assign b2.htrans = (sel == 2'd2) ? htrans : 2'b00;
  assign b2.haddr  = (sel == 2'd2) ? haddr  : 32'h0;
  assign b2.hwrite = (sel == 2'd2) ? hwrite : 1'b0;
  assign b2.hwdata = (sel == 2'd2) ? hwdata : 32'h0;

  always_comb begin
    cur_hready = b0.hready;
    cur_hresp  = b0.hresp;
    cur_hrdata = b0.hrdata;
    case (sel)
      2'd1: begin
        cur_hready = b1.hready;
        cur_hresp  = b1.hresp;
        cur_hrdata = b1.hrdata;
      end
      2'd2: begin
        cur_hready = b2.hready;
        cur_hresp  = b2.hresp;
        cur_hrdata = b2.hrdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] rd_count0, wr_count0, rd_count1, wr_count1, rd_count2, wr_count2;
`endif

  ahb_mem_responder #(.WAIT_STATES(1)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(b0)
`ifdef MEM_ACCESS_COUNT_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  ahb_mem_responder #(.WAIT_STATES(0)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(b1)
`ifdef MEM_ACCESS_COUNT_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  ahb_mem_responder #(.WAIT_STATES(3)) dut2 (
    .clk(clk), .n_rst(n_rst), .bus(b2)
`ifdef MEM_ACCESS_COUNT_EN
    , .rd_count(rd_count2), .wr_count(wr_count2)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer, started with the bus idle and hready high.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp,
                      output logic first_resp, output int low);
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    @(posedge clk); #1;
    first_resp = cur_hresp;
    htrans = 2'b00;
    hwdata = wdata;
    low = 0;
    while (!cur_hready && low < 40) begin
      low++;
      @(posedge clk); #1;
    end
    rdata = cur_hrdata;
    resp  = cur_hresp;
    @(posedge clk); #1;
  endtask

  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_resp, input int exp_low);
    logic [31:0] rdata;
    logic        resp;
    logic        first_resp;
    int          low;
    xfer(wr, addr, wdata, rdata, resp, first_resp, low);
    check_eq({tag, "_low"}, 32'(low), 32'(exp_low));
    check_eq({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    if (exp_low > 0) check_eq({tag, "_resp_wait"}, 32'(first_resp), 32'(exp_resp));
    if (!wr && !exp_resp) check_eq({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_rst  = 1'b0;
    sel    = 2'd0;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values on every instance.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check_eq($sformatf("rst%0d_hready", s), 32'(cur_hready), 32'd1);
      check_eq($sformatf("rst%0d_hresp", s), 32'(cur_hresp), 32'd0);
      check_eq($sformatf("rst%0d_hrdata", s), cur_hrdata, 32'h0);
    end
    sel = 2'd0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // One wait state: write then read back.
    txn("ws1_wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    txn("ws1_rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
    txn("ws1_wr14", 1'b1, 32'h14, 32'h1111_1111, 32'h0, 1'b0, 1);
    check_eq("hrdata_hold", cur_hrdata, 32'hDEAD_BEEF);

    // BUSY is not a transfer.
    htrans = 2'b01;
    haddr  = 32'h10;
    @(posedge clk); #1;
    check_eq("busy_hready", 32'(cur_hready), 32'd1);
    check_eq("busy_hresp", 32'(cur_hresp), 32'd0);
    htrans = 2'b00;
    @(posedge clk); #1;

    // Out-of-window accesses and the top in-range word.
    txn("wr00", 1'b1, 32'h0, 32'hA5A5_A5A5, 32'h0, 1'b0, 1);
    txn("err_wr", 1'b1, 32'h1000, 32'hBAD0_BAD0, 32'h0, 1'b1, 1);
    txn("err_rd", 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    txn("rd00", 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, 1);
    txn("wr_top", 1'b1, 32'hFFC, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
    txn("rd_top", 1'b0, 32'hFFC, 32'h0, 32'hCAFE_F00D, 1'b0, 1);

    // Zero wait states: pipelined write then read of the same word.
    sel = 2'd1;
    #1;
    txn("ws0_wr20_old", 1'b1, 32'h20, 32'h0BAD_0BAD, 32'h0, 1'b0, 0);
    htrans = 2'b10;
    haddr  = 32'h20;
    hwrite = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b_wr_hready", 32'(cur_hready), 32'd1);
    htrans = 2'b10;
    haddr  = 32'h20;
    hwrite = 1'b0;
    hwdata = 32'h1234_5678;
    @(posedge clk); #1;
    check_eq("b2b_rd_hready", 32'(cur_hready), 32'd1);
    check_eq("b2b_rd_hresp", 32'(cur_hresp), 32'd0);
    check_eq("b2b_fwd_data", cur_hrdata, 32'h1234_5678);
    htrans = 2'b00;
    @(posedge clk); #1;
    check_eq("b2b_end_hready", 32'(cur_hready), 32'd1);
    txn("ws0_rd20", 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 0);

    // Three wait states: preload then read back in order.
    sel = 2'd2;
    #1;
    for (int i = 0; i < 4; i++)
      txn($sformatf("ws3_wr%0d", i), 1'b1, 32'(4 * i), 32'(i + 1), 32'h0, 1'b0, 3);
    for (int i = 0; i < 4; i++)
      txn($sformatf("ws3_rd%0d", i), 1'b0, 32'(4 * i), 32'h0, 32'(i + 1), 1'b0, 3);

    // Reset during the wait state of a write discards it.
    sel = 2'd0;
    #1;
    txn("wr40_zero", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0, 1);
    htrans = 2'b10;
    haddr  = 32'h40;
    hwrite = 1'b1;
    @(posedge clk); #1;
    check_eq("pre_rst_hready", 32'(cur_hready), 32'd0);
    htrans = 2'b00;
    hwdata = 32'h55AA_55AA;
    n_rst  = 1'b0;
    #1;
    check_eq("mid_rst_hready", 32'(cur_hready), 32'd1);
    check_eq("mid_rst_hresp", 32'(cur_hresp), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    txn("rd40_after_rst", 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1);

`ifdef MEM_ACCESS_COUNT_EN
    // Access counters: 5 writes, 7 reads, 1 error.
    pulse_reset();
    check_eq("cnt_rst_wr", wr_count0, 32'd0);
    check_eq("cnt_rst_rd", rd_count0, 32'd0);
    for (int i = 0; i < 5; i++)
      txn($sformatf("cnt_wr%0d", i), 1'b1, 32'(32'h100 + 4 * i), 32'(i + 7), 32'h0, 1'b0, 1);
    for (int i = 0; i < 7; i++)
      txn($sformatf("cnt_rd%0d", i), 1'b0, 32'(32'h100 + 4 * (i % 5)), 32'h0,
          32'((i % 5) + 7), 1'b0, 1);
    txn("cnt_err", 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 1);
    check_eq("wr_count", wr_count0, 32'd5);
    check_eq("rd_count", rd_count0, 32'd7);
`else
    pulse_reset();
    check_eq("final_rst_hready", 32'(cur_hready), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
